// File: rtl/pool_pkg.sv
// ---------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the pooling engine: FSM state encoding, pooling
// mode encoding, the legal window sizes and the accumulator width.
// Helper functions map a raw window request onto a legal window and give
// the right-shift that turns a window sum into an average.
// ---------------------------------------------------------------------------
package pool_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } pool_state_e;

    typedef enum logic {
        MODE_AVG = 1'b0,
        MODE_MAX = 1'b1
    } pool_mode_e;

    localparam logic [2:0] WIN_K1 = 3'd1;
    localparam logic [2:0] WIN_K2 = 3'd2;
    localparam logic [2:0] WIN_K4 = 3'd4;

    // A KxK window of DW-bit values needs 2*log2(4) = 4 extra bits at most.
    localparam int ACC_GUARD_BITS = 4;

    function automatic int accWidth(input int dw);
        return dw + ACC_GUARD_BITS;
    endfunction

    // Anything that is not 2 or 4 collapses to a 1x1 window.
    function automatic logic [2:0] legalWindow(input logic [2:0] k);
        if (k == WIN_K2 || k == WIN_K4) begin
            return k;
        end
        return WIN_K1;
    endfunction

    // Dividing by K*K is a shift by 2*log2(K).
    function automatic logic [2:0] windowShift(input logic [2:0] k);
        case (k)
            WIN_K4:  return 3'd4;
            WIN_K2:  return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/pool_lane_reduce.sv
// ---------------------------------------------------------------------------
// pool_lane_reduce
// One output lane of the pooling engine. Each accepted row contributes the
// K adjacent input elements belonging to this lane; they are summed (and,
// with POOL_MAX_MODE_EN, max-reduced) into running accumulators that are
// cleared between windows.
//
// Ports:
//   clk, resetn   clock and asynchronous active-low reset
//   k_i           legal window size (1, 2 or 4)
//   active_i      lane lies inside the N/K pooled lanes
//   accept_i      a row is being accepted this cycle
//   clear_i       drop accumulated state
//   mode_i        1 = max pooling (only with POOL_MAX_MODE_EN)
//   win1_i/2_i/4_i  this lane's input elements for K = 1, 2, 4
//   result_o      pooled value for this lane
//
// Configuration macro: POOL_MAX_MODE_EN adds max pooling.
// ---------------------------------------------------------------------------
module pool_lane_reduce
    import pool_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [2:0]        k_i,
    input  logic              active_i,
    input  logic              accept_i,
    input  logic              clear_i,
`ifdef POOL_MAX_MODE_EN
    input  logic              mode_i,
`endif
    input  logic [DW-1:0]     win1_i,
    input  logic [2*DW-1:0]   win2_i,
    input  logic [4*DW-1:0]   win4_i,
    output logic [DW-1:0]     result_o
);

    localparam int ACC_W = accWidth(DW);

    logic [DW-1:0]    elem [4];
    logic [ACC_W-1:0] rowSum;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [DW-1:0]    avgValue;

    // Elements outside the current window are forced to zero so they add
    // nothing to the sum and never win the max.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            elem[i] = '0;
        end
        case (k_i)
            WIN_K4: begin
                for (int i = 0; i < 4; i++) begin
                    elem[i] = win4_i[i*DW +: DW];
                end
            end
            WIN_K2: begin
                elem[0] = win2_i[0 +: DW];
                elem[1] = win2_i[DW +: DW];
            end
            default: elem[0] = win1_i;
        endcase
    end

    always_comb begin
        rowSum = ACC_W'(elem[0]) + ACC_W'(elem[1]) + ACC_W'(elem[2]) + ACC_W'(elem[3]);
        acc_d  = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (accept_i) begin
            acc_d = acc_q + rowSum;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Missing rows of a partial window simply never added anything, so the
    // shift still divides by the full K*K.
    assign avgValue = DW'(acc_q >> windowShift(k_i));

`ifdef POOL_MAX_MODE_EN
    logic [DW-1:0] rowMax;
    logic [DW-1:0] max_q;
    logic [DW-1:0] max_d;

    always_comb begin
        rowMax = elem[0];
        for (int i = 1; i < 4; i++) begin
            if (elem[i] > rowMax) begin
                rowMax = elem[i];
            end
        end
        max_d = max_q;
        if (clear_i) begin
            max_d = '0;
        end else if (accept_i && rowMax > max_q) begin
            max_d = rowMax;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign result_o = !active_i ? '0 : (mode_i ? max_q : avgValue);
`else
    assign result_o = active_i ? avgValue : '0;
`endif

endmodule

// File: rtl/pool_engine.sv
// ---------------------------------------------------------------------------
// pool_engine
// Streaming KxK pooling over rows of N lanes. Rows arrive on a valid/ready
// input; every K rows (or the last row of the job) produce one pooled row on
// a valid/ready output. With enable_pool low the block is a plain wire.
//
// Ports:
//   clk, resetn            clock and asynchronous active-low reset
//   enable_pool            engine enable (low = combinational bypass)
//   pool_window_size       window K (1, 2 or 4; anything else means 1)
//   pool_mode              0 = average, 1 = max (max needs POOL_MAX_MODE_EN)
//   num_rows               input rows per job
//   in_valid/in_ready/in_data     input row stream
//   out_valid/out_ready/out_data  pooled row stream
//   done_pool              job complete
//   busy                   job in progress
//
// Configuration macro: POOL_MAX_MODE_EN enables max pooling; without it
// pool_mode is ignored and only averaging is built.
// ---------------------------------------------------------------------------
module pool_engine
    import pool_pkg::*;
#(
    parameter int N  = 8,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            enable_pool,
    input  logic [2:0]      pool_window_size,
    input  logic            pool_mode,
    input  logic [15:0]     num_rows,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*DW-1:0] out_data,
    output logic            done_pool,
    output logic            busy
);

    pool_state_e state_q;
    logic [2:0]  k_q;
    logic [15:0] numRows_q;
    logic [15:0] rowCount_q;
    logic [2:0]  groupCount_q;
    logic        outValid_q;
    logic        done_q;
    logic        busy_q;

    logic            accept;
    logic            transfer;
    logic            abort;
    logic            clearAcc;
    logic [15:0]     rowCountInc;
    logic            groupFull;
    logic            lastRow;
    logic [N*DW-1:0] poolData;

`ifdef POOL_MAX_MODE_EN
    pool_mode_e mode_q;
`else
    // Averaging only: the mode input is deliberately left unused.
    logic unusedMode;
    assign unusedMode = pool_mode;
`endif

    assign accept      = enable_pool && (state_q == ST_ACCUM) && in_valid;
    assign transfer    = enable_pool && (state_q == ST_EMIT) && out_ready;
    assign abort       = !enable_pool && ((state_q == ST_ACCUM) || (state_q == ST_EMIT));
    assign clearAcc    = transfer || abort || (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign rowCountInc = rowCount_q + 16'd1;
    assign groupFull   = (groupCount_q + 3'd1) == k_q;
    assign lastRow     = rowCountInc == numRows_q;

    // Control FSM; out_valid, done and busy are registered alongside the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            k_q          <= WIN_K1;
            numRows_q    <= '0;
            rowCount_q   <= '0;
            groupCount_q <= '0;
            outValid_q   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
`ifdef POOL_MAX_MODE_EN
            mode_q       <= MODE_AVG;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_pool) begin
                        k_q          <= legalWindow(pool_window_size);
                        numRows_q    <= num_rows;
                        rowCount_q   <= '0;
                        groupCount_q <= '0;
`ifdef POOL_MAX_MODE_EN
                        mode_q       <= pool_mode_e'(pool_mode);
`endif
                        if (num_rows == 16'd0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ACCUM;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (!enable_pool) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (in_valid) begin
                        rowCount_q <= rowCountInc;
                        if (groupFull || lastRow) begin
                            groupCount_q <= '0;
                            state_q      <= ST_EMIT;
                            outValid_q   <= 1'b1;
                        end else begin
                            groupCount_q <= groupCount_q + 3'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (!enable_pool) begin
                        state_q    <= ST_IDLE;
                        outValid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (out_ready) begin
                        outValid_q <= 1'b0;
                        if (rowCount_q == numRows_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_ACCUM;
                        end
                    end
                end
                ST_DONE: begin
                    if (!enable_pool) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Each output lane gets the K-wide slice of the row it reduces; slices
    // that would run past lane N-1 are tied off and the lane reports 0.
    for (genvar j = 0; j < N; j++) begin : g_lane
        localparam bit LANE2_OK = (2*j + 1) < N;
        localparam bit LANE4_OK = (4*j + 3) < N;

        logic [2*DW-1:0] win2;
        logic [4*DW-1:0] win4;
        logic            active;
        logic [DW-1:0]   laneResult;

        if (LANE2_OK) begin : g_win2
            assign win2 = in_data[2*j*DW +: 2*DW];
        end else begin : g_nowin2
            assign win2 = '0;
        end

        if (LANE4_OK) begin : g_win4
            assign win4 = in_data[4*j*DW +: 4*DW];
        end else begin : g_nowin4
            assign win4 = '0;
        end

        assign active = (k_q == WIN_K4) ? LANE4_OK :
                        (k_q == WIN_K2) ? LANE2_OK : 1'b1;

        pool_lane_reduce #(
            .DW(DW)
        ) u_lane (
            .clk      (clk),
            .resetn   (resetn),
            .k_i      (k_q),
            .active_i (active),
            .accept_i (accept),
            .clear_i  (clearAcc),
`ifdef POOL_MAX_MODE_EN
            .mode_i   (mode_q == MODE_MAX),
`endif
            .win1_i   (in_data[j*DW +: DW]),
            .win2_i   (win2),
            .win4_i   (win4),
            .result_o (laneResult)
        );

        assign poolData[j*DW +: DW] = laneResult;
    end

    // Bypass is purely combinational; reset still forces the outputs quiet.
    assign in_ready  = enable_pool ? (state_q == ST_ACCUM) : out_ready;
    assign out_valid = resetn && (enable_pool ? outValid_q : in_valid);
    assign out_data  = !resetn     ? '0 :
                       enable_pool ? (outValid_q ? poolData : '0) : in_data;
    assign done_pool = resetn && (enable_pool ? done_q : 1'b1);
    assign busy      = enable_pool && busy_q;

endmodule

// File: doc/pool_engine.md
POOL_ENGINE -- requirements
Module: pool_engine

Interface
REQ-001 SHALL have parameter N, default 8, giving the number of lanes per row (power of two, at least 4).
REQ-002 SHALL have parameter DW, default 8, giving the unsigned element width in bits.
REQ-003 SHALL have ports: clk  in  1  sole clock; resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: enable_pool  in  1  engine enable; pool_window_size  in  3  window K (1, 2 or 4); pool_mode  in  1  0 = average, 1 = max; num_rows  in  16  input rows per job.
REQ-005 SHALL have ports: in_valid  in  1; in_ready  out  1; in_data  in  N*DW  input row, lane i at bits [i*DW +: DW].
REQ-006 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  N*DW  pooled row; done_pool  out  1  job complete; busy  out  1  job in progress.

Function
REQ-007 SHALL, when enable_pool=0, bypass combinationally: out_data=in_data, out_valid=in_valid, in_ready=out_ready, done_pool=1, busy=0.
REQ-008 SHALL implement states IDLE, ACCUM, EMIT and DONE.
REQ-009 SHALL, in IDLE with enable_pool=1, latch K, mode and num_rows, then go to ACCUM; if num_rows=0 it SHALL go to DONE instead.
REQ-010 SHALL treat any pool_window_size other than 1, 2 or 4 as K=1.
REQ-011 SHALL drive in_ready=1 only in ACCUM; a row is accepted on a cycle with in_valid && in_ready.
REQ-012 SHALL, for output lane j < N/K, reduce input lanes j*K .. j*K+K-1 over K consecutive accepted rows (a KxK window); lanes j >= N/K SHALL output 0.
REQ-013 SHALL, in average mode, sum in an accumulator of DW+4 bits (no overflow) and output sum >> (2*log2 K), truncated to DW bits.
REQ-014 SHALL, in max mode, output the unsigned maximum of the window.
REQ-015 SHALL go to EMIT on the cycle the K-th row of a group, or the final row of the job, is accepted; out_valid SHALL rise on the next cycle (latency 1 cycle after the last accept).
REQ-016 SHALL hold out_valid and out_data stable in EMIT until out_ready=1; after the transfer it SHALL clear the accumulators and go to ACCUM, or to DONE if num_rows rows have been accepted.
REQ-017 SHALL handle a partial final group (num_rows not a multiple of K) as follows: average mode still divides by K*K (missing rows count as zero); max mode uses only the rows received.
REQ-018 SHALL, in DONE, hold done_pool=1 until enable_pool=0, then return to IDLE.
REQ-019 SHALL drive busy=1 in ACCUM and EMIT only.
REQ-020 SHALL, if enable_pool falls in ACCUM or EMIT, discard the partial result and go to IDLE on the next clock edge; no output transfer SHALL occur on that edge.

Reset
REQ-021 SHALL, while resetn=0, force the state to IDLE, clear the accumulators and row counter, and drive out_valid=0, out_data=0, done_pool=0 and busy=0; in_ready SHALL follow REQ-007 or REQ-011.
REQ-022 SHALL take effect on assertion of resetn regardless of clk, and release synchronously to clk.

Configuration
REQ-023 SHALL compile in max mode only when POOL_MAX_MODE_EN is defined.
REQ-024 SHALL, without POOL_MAX_MODE_EN, ignore pool_mode, always average, and contain no comparator logic.

Structure
REQ-025 SHALL take the state encoding, the mode encoding, the legal window constants (1, 2, 4) and the accumulator width (DW+4) from package pool_pkg.
REQ-026 SHALL place per-output-lane horizontal reduction and accumulation in sub-module pool_lane_reduce, instantiated N times by generate.

Verification (N=8, DW=8)
REQ-027 SHALL cover: K=1, average, num_rows=2 -> each output row equals its input row; done_pool=1 after the second transfer.
REQ-028 SHALL cover: K=2, average, row0 lanes 0..3 = 10,20,30,40, row1 lanes 0..3 = 30,40,50,60 -> out lane0 = 25, lane1 = 45, lanes 4..7 = 0.
REQ-029 SHALL cover: K=2, max (POOL_MAX_MODE_EN defined), same rows as REQ-028 -> lane0 = 40, lane1 = 60.
REQ-030 SHALL cover: out_ready held low for 3 cycles in EMIT -> out_valid=1, in_ready=0 and out_data unchanged throughout; single transfer when out_ready rises.
REQ-031 SHALL cover: K=2, average, num_rows=3, every element 100 -> two outputs: lanes 0..3 = 100, then lanes 0..3 = 50.
REQ-032 SHALL cover: resetn pulsed low in ACCUM after one accepted row -> outputs clear immediately; the next job's first result excludes the discarded row.
